uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter paired with the existing 8-bit serial receiver. It takes a byte from a local producer over a valid/ready handshake and serialises it onto one line as 8N1: start bit, 8 data bits LSB first, optional parity bit, stop bit. The line idles high. Default bit timing is 400 sys_clk cycles per bit, matching the receiver, so the two blocks loop back directly.

Parameters:
CLKS_PER_BIT, 400, sys_clk cycles per serial bit; legal range 2..65535.
PARITY_EN, 0, 1 inserts a parity bit between D7 and the stop bit.
PARITY_ODD, 0, used only when PARITY_EN=1; 1 gives odd parity, 0 gives even parity.

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge.
sys_rst  input  1  reset, synchronous, active-high.
din      input  8  byte to transmit; sampled only on the accept edge.
din_vld  input  1  producer offers din.
din_rdy  output 1  block can accept a byte; registered.
bit_out  output 1  serial line; registered; idles high.
busy     output 1  a frame is in progress; this is the inverse of din_rdy.
tx_done  output 1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (sys_clk, sys_rst).
- Reset values: bit_out=1, din_rdy=1, busy=0, tx_done=0, FSM=IDLE, counters=0, shift register=0.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Accept: a byte is accepted on an edge T where din_vld && din_rdy.
  - At T, din is loaded into the shift register.
  - Parity is computed from din at T: XOR of the 8 bits, XNOR for odd.
  - din_rdy goes 0 and busy goes 1.
  - The FSM enters START.
- din_vld is ignored while din_rdy=0. din may change after T without effect.
- Line timing, with N=CLKS_PER_BIT and P=PARITY_EN, all cycles counted after T:
  - bit_out=0 (start) for cycles T+1..T+N.
  - Data bit i (i=0..7, LSB first) for cycles T+1+(i+1)N .. T+(i+2)N.
  - Parity bit, if enabled, for N cycles after D7.
  - bit_out=1 (stop) for the final N cycles, ending at cycle T+(10+P)N.
- Bit counter: counts 0..N-1 and wraps. Each state advances when the counter reaches N-1. The width is sized to hold N-1.
- Data bit index: runs 0..7. DATA exits when index=7 and the counter reaches N-1.
- tx_done=1 only in cycle T+(10+P)N. In the next cycle: IDLE, din_rdy=1, busy=0, bit_out stays 1.
- Back-to-back: the earliest next accept is the edge at T+(10+P)N+1. This gives a frame period of (10+P)N+1 cycles, i.e. exactly 1 extra idle-high cycle between frames.
- Reset mid-frame: the frame is abandoned. On the cycle after sys_rst is sampled high, all reset values apply and bit_out=1. A truncated frame is acceptable. No tx_done is generated for it.
- sys_rst high together with din_vld: reset wins and nothing is accepted.
- bit_out is driven directly from a flop, with no combinational path to the pin, to avoid glitches.

Test Plan:
1. Reset and idle: hold sys_rst for 3 cycles, then release with din_vld=0 for 1000 cycles -> bit_out=1, din_rdy=1, busy=0, tx_done=0 throughout.
2. Single byte, default parameters: din=8'h55 accepted at T.
   - Sampling bit_out at T+200+400k for k=0..9 yields 0,1,0,1,0,1,0,1,0,1.
   - tx_done is high only at T+4000.
   - din_rdy returns to 1 at T+4001.
3. Back-to-back with din_vld held high: send 8'hA5 then 8'h3C.
   - The second accept occurs at T+4001.
   - Exactly one idle-high cycle separates the frames.
   - Decoded bits match LSB-first A5 then 3C.
   - The value on din during the first frame is ignored.
4. Parity: PARITY_EN=1, PARITY_ODD=0, CLKS_PER_BIT=16.
   - din=8'h07 gives parity bit 1; din=8'h03 gives parity bit 0.
   - With PARITY_ODD=1 both values invert.
   - The frame is 11*16 cycles and tx_done is at T+176.
5. Reset mid-frame: assert sys_rst during data bit 3 of 8'h00.
   - The next cycle shows bit_out=1, din_rdy=1, busy=0, and no tx_done.
   - A following 8'hFF frame is sent correctly.
6. Loopback: connect bit_out to the receiver's bit_in and send 8'h00, 8'hFF, 8'h5A, 8'hC3 back-to-back. The receiver pulses dout_vld once per frame with a matching dout.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (optional parity) with a valid/ready byte input.
// The serial line and all handshake outputs come straight from flops.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 400,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy,
  output logic       bit_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             bit_q, bit_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_MAX);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; registered outputs are derived from the next state so
  // every pin changes on the same edge as the state it reflects.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        bit_d = 1'b1;
        if (din_vld && rdy_q) begin
          shift_d = din;
          par_d   = PARITY_ODD ? ~(^din) : ^din;
          bit_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (wrap) begin
          cnt_d   = '0;
          bit_d   = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (wrap) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            if (PARITY_EN) begin
              bit_d   = par_q;
              state_d = S_PARITY;
            end else begin
              bit_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (wrap) begin
          cnt_d   = '0;
          bit_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (wrap) begin
          cnt_d   = '0;
          bit_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        bit_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX);
  end

  assign din_rdy = rdy_q;
  assign bit_out = bit_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (default, even parity, odd parity)
// checked cycle by cycle against a frame-timing model plus a behavioural receiver.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] vld = '0;
  logic [7:0] din_a [3];
  wire  [2:0] line_w, rdy_w, busy_w, done_w;

  int n_cmp = 0;
  int n_err = 0;

  logic cap_line[$], cap_done[$], cap_rdy[$], cap_busy[$];
  logic [7:0] rx_q[$];
  bit rx_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx u_def (
    .sys_clk(clk), .sys_rst(rst), .din(din_a[0]), .din_vld(vld[0]),
    .din_rdy(rdy_w[0]), .bit_out(line_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .sys_clk(clk), .sys_rst(rst), .din(din_a[1]), .din_vld(vld[1]),
    .din_rdy(rdy_w[1]), .bit_out(line_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .sys_clk(clk), .sys_rst(rst), .din(din_a[2]), .din_vld(vld[2]),
    .din_rdy(rdy_w[2]), .bit_out(line_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

  function automatic int n_of(input int sel);
    return (sel == 0) ? 400 : 16;
  endfunction

  function automatic bit p_of(input int sel);
    return (sel != 0);
  endfunction

  function automatic bit odd_of(input int sel);
    return (sel == 2);
  endfunction

  function automatic int frame_len(input int sel);
    return (10 + int'(p_of(sel))) * n_of(sel);
  endfunction

  // Expected line level in cycle T+k (k >= 1) after accepting byte b at edge T.
  function automatic logic exp_line(input int sel, input logic [7:0] b, input int k);
    int n;
    int idx;
    n = n_of(sel);
    if (k > frame_len(sel)) return 1'b1;
    idx = (k - 1) / n;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (p_of(sel) && idx == 9) return odd_of(sel) ? ~(^b) : ^b;
    return 1'b1;
  endfunction

  // Number of captured cycles (T+1 .. T+F+1) that disagree with the model.
  function automatic int frame_bad(input int sel, input logic [7:0] b);
    int f;
    int bad;
    f = frame_len(sel);
    bad = 0;
    if (cap_line.size() < f + 1) return f + 1;
    for (int k = 1; k <= f + 1; k++) begin
      if (cap_line[k-1] !== exp_line(sel, b, k) || cap_done[k-1] !== (k == f) ||
          cap_rdy[k-1] !== (k == f + 1) || cap_busy[k-1] !== (k != f + 1))
        bad++;
    end
    return bad;
  endfunction

  // Offer b and return just after the accepting edge (#1 past it).
  task automatic send(input int sel, input logic [7:0] b, input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    din_a[sel] = b;
    vld[sel]   = 1'b1;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (rdy_w[sel] === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout sel=%0d byte=%02h: din_rdy never 1 within budget", sel, b);
    end
    @(posedge clk);
    #1;
    if (!hold) vld[sel] = 1'b0;
    din_a[sel] = 8'($urandom);
  endtask

  task automatic capture(input int sel, input int ncyc);
    cap_line.delete(); cap_done.delete(); cap_rdy.delete(); cap_busy.delete();
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      cap_line.push_back(line_w[sel]);
      cap_done.push_back(done_w[sel]);
      cap_rdy.push_back(rdy_w[sel]);
      cap_busy.push_back(busy_w[sel]);
    end
  endtask

  // Behavioural 8N1 receiver on the default-config line: mid-bit sampling.
  initial begin
    logic [7:0] rb;
    forever begin
      @(posedge clk);
      if (rx_en && line_w[0] === 1'b0) begin
        repeat (199) @(posedge clk);
        if (line_w[0] === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (400) @(posedge clk);
            rb[i] = line_w[0];
          end
          repeat (400) @(posedge clk);
          if (line_w[0] === 1'b1) rx_q.push_back(rb);
        end
      end
    end
  end

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    vld = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({line_w, rdy_w, busy_w, done_w} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: line=%b rdy=%b busy=%b done=%b want 111/111/000/000",
               line_w, rdy_w, busy_w, done_w);
    end
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({line_w, rdy_w, busy_w, done_w} !== {3'b111, 3'b111, 3'b000, 3'b000}) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle_hold: %0d bad idle cycles, want 0", bad);
    end
  endtask

  task automatic test_single_byte;
    logic [9:0] want;
    int bad;
    int dcnt;
    want = 10'b1010101010;
    send(0, 8'h55, 1'b0);
    capture(0, 4001);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (cap_line[200 + 400*k - 1] !== want[k]) begin
        n_err++;
        $display("FAIL bit_sample_%0d: got %b want %b", k, cap_line[200 + 400*k - 1], want[k]);
      end
    end
    dcnt = 0;
    foreach (cap_done[i]) if (cap_done[i] === 1'b1) dcnt++;
    n_cmp++;
    if (cap_done[3999] !== 1'b1 || dcnt != 1) begin
      n_err++;
      $display("FAIL done_at_4000: done[T+4000]=%b pulses=%0d want 1/1", cap_done[3999], dcnt);
    end
    n_cmp++;
    if (cap_rdy[3999] !== 1'b0 || cap_rdy[4000] !== 1'b1) begin
      n_err++;
      $display("FAIL rdy_return: rdy[T+4000]=%b rdy[T+4001]=%b want 0/1", cap_rdy[3999], cap_rdy[4000]);
    end
    bad = frame_bad(0, 8'h55);
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL frame_55: %0d cycles differ from model, want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    send(0, 8'hA5, 1'b1);
    din_a[0] = 8'h3C;
    capture(0, 4001);
    bad = frame_bad(0, 8'hA5);
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_frame_a5: %0d cycles differ, want 0", bad);
    end
    // vld still high: the edge right after the single idle cycle accepts 3C
    capture(0, 4001);
    vld[0] = 1'b0;
    n_cmp++;
    if (cap_busy[0] !== 1'b1 || cap_line[0] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept_at_4001: busy=%b line=%b want 1/0", cap_busy[0], cap_line[0]);
    end
    bad = frame_bad(0, 8'h3C);
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_frame_3c: %0d cycles differ, want 0", bad);
    end
  endtask

  task automatic test_parity;
    logic [7:0] vals [2];
    logic pw;
    int bad;
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    for (int sel = 1; sel <= 2; sel++) begin
      for (int v = 0; v < 2; v++) begin
        send(sel, vals[v], 1'b0);
        capture(sel, 177);
        pw = (v == 0) ? 1'b1 : 1'b0;
        if (sel == 2) pw = ~pw;
        n_cmp++;
        if (cap_line[151] !== pw) begin
          n_err++;
          $display("FAIL parity_bit sel=%0d byte=%02h: got %b want %b", sel, vals[v], cap_line[151], pw);
        end
        n_cmp++;
        if (cap_done[175] !== 1'b1) begin
          n_err++;
          $display("FAIL parity_done_176 sel=%0d: got %b want 1", sel, cap_done[175]);
        end
        bad = frame_bad(sel, vals[v]);
        n_cmp++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL parity_frame sel=%0d byte=%02h: %0d cycles differ", sel, vals[v], bad);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    int sel;
    int bad;
    for (int t = 0; t < 12; t++) begin
      sel = 1 + (t % 2);
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(sel, b, 1'b0);
      capture(sel, 177);
      bad = frame_bad(sel, b);
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL random_frame sel=%0d byte=%02h: %0d cycles differ", sel, b, bad);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    send(0, 8'h00, 1'b0);
    repeat (1700) @(negedge clk);
    n_cmp++;
    if (line_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_frame_pre: line=%b busy=%b want 0/1", line_w[0], busy_w[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({line_w[0], rdy_w[0], busy_w[0], done_w[0]} !== 4'b1100) begin
      n_err++;
      $display("FAIL mid_frame_reset: line/rdy/busy/done=%b want 1100",
               {line_w[0], rdy_w[0], busy_w[0], done_w[0]});
    end
    bad = 0;
    repeat (2500) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || line_w[0] !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abandoned_frame_quiet: %0d bad cycles, want 0", bad);
    end
    // reset together with a valid byte: nothing may be accepted
    @(negedge clk);
    rst = 1'b1;
    din_a[0] = 8'hAA;
    vld[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vld[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_w[0] !== 1'b0 || line_w[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_wins: busy=%b line=%b want 0/1", busy_w[0], line_w[0]);
    end
    send(0, 8'hFF, 1'b0);
    capture(0, 4001);
    bad = frame_bad(0, 8'hFF);
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL post_reset_ff: %0d cycles differ, want 0", bad);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] msg [4];
    msg[0] = 8'h00; msg[1] = 8'hFF; msg[2] = 8'h5A; msg[3] = 8'hC3;
    rx_q.delete();
    rx_en = 1'b1;
    for (int j = 0; j < 4; j++) send(0, msg[j], 1'b1);
    vld[0] = 1'b0;
    repeat (4200) @(negedge clk);
    rx_en = 1'b0;
    n_cmp++;
    if (rx_q.size() != 4) begin
      n_err++;
      $display("FAIL loopback_count: got %0d bytes want 4", rx_q.size());
    end
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (j >= rx_q.size() || rx_q[j] !== msg[j]) begin
        n_err++;
        $display("FAIL loopback_byte_%0d: got %02h want %02h", j,
                 (j < rx_q.size()) ? rx_q[j] : 8'hxx, msg[j]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) din_a[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_random();
    test_reset_mid_frame();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
